eth_tx_framer: RTL and testbench

ETH_TX_FRAMER -- requirements
Module: eth_tx_framer

---
 rtl/eth_pkg.sv | 47 ++++
 rtl/eth_tx_framer_if.sv | 26 ++
 rtl/eth_crc32_nibble.sv | 25 ++
 rtl/eth_tx_framer.sv | 227 ++++++++++++++++++++++
 tb/tb_eth_tx_framer.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet MII transmit framer.
// State encoding, framing nibbles, CRC-32 constants and the nibble-wide
// CRC update used by eth_crc32_nibble.
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_DATA     = 3'd3,
        ST_FCS      = 3'd4,
        ST_ABORT    = 3'd5,
        ST_IFG      = 3'd6
    } eth_state_e;

    localparam logic [3:0]  PREAMBLE_NIBBLE  = 4'h5;
    localparam logic [3:0]  SFD_NIBBLE       = 4'hD;
    localparam int          PREAMBLE_LEN     = 15;
    localparam int          NIBBLES_PER_WORD = 8;

    localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    // Bit-reverse a 32-bit word; Ethernet sends LSB first, so the CRC
    // runs with the reflected polynomial.
    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    localparam logic [31:0] CRC_POLY_REFL = reflect32(CRC_POLY);

    // Advance a reflected CRC-32 by one nibble (bit 0 of the nibble first).
    function automatic logic [31:0] crc32_nibble(input logic [31:0] crc,
                                                 input logic [3:0]  nib);
        logic [31:0] c;
        c = crc ^ {28'h0, nib};
        for (int i = 0; i < 4; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_tx_framer_if.sv
// TX FIFO read port as seen by the framer.
//
// Handshake: the FIFO head word i_fifo_data is valid whenever i_fifo_empty
// is low (first-word-fall-through). The framer pulses o_fifo_rd for one
// cycle per word; the word transfers, and the FIFO pops, on the rising
// edge that ends a cycle with o_fifo_rd high. o_fifo_rd is only raised
// when the framer has already seen the FIFO non-empty.
interface eth_tx_framer_if;

    logic        i_fifo_empty;
    logic [31:0] i_fifo_data;
    logic        o_fifo_rd;

    modport master (
        input  i_fifo_empty,
        input  i_fifo_data,
        output o_fifo_rd
    );

    modport slave (
        output i_fifo_empty,
        output i_fifo_data,
        input  o_fifo_rd
    );

endinterface

// File: rtl/eth_crc32_nibble.sv
// Nibble-serial Ethernet CRC-32 accumulator.
// clear reloads the init value; enable folds din into the running state.
module eth_crc32_nibble
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        enable,
    input  logic [3:0]  din,
    output logic [31:0] crc
);

    // Running CRC register; clear wins over enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc <= CRC_INIT;
        end else if (clear) begin
            crc <= CRC_INIT;
        end else if (enable) begin
            crc <= crc32_nibble(crc, din);
        end
    end

endmodule

// File: rtl/eth_tx_framer.sv
// Ethernet MII transmit framer: preamble, SFD, payload words from a FWFT
// FIFO, optional FCS, then inter-frame gap.
// Optional feature macro: ETH_TX_FCS_EN (adds the CRC-32 FCS trailer).
//
// All outputs are registered from the next-state logic, so the state
// register always names the phase currently on the MII pins. FIFO reads
// are decided one cycle ahead of each load point so o_fifo_rd can be a
// register; the FIFO is only popped by this block, so a non-empty flag
// seen one cycle early still holds at the load edge.
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter int IFG_NIBBLES = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_tx_start,
    input  logic [8:0]            i_word_count,
    eth_tx_framer_if.master       fifo,
    output logic [3:0]            o_txd,
    output logic                  o_tx_en,
    output logic                  o_tx_er,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_underrun,
    output eth_state_e            dbg_state
);

    localparam logic [15:0] PRE_LAST  = 16'(PREAMBLE_LEN - 1);
    localparam logic [15:0] WORD_LAST = 16'(NIBBLES_PER_WORD - 1);
    localparam logic [15:0] IFG_LAST  = 16'(IFG_NIBBLES - 1);

    eth_state_e  state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [8:0]  words_left, words_n;
    logic [31:0] shreg, shreg_n;
    logic        aborted, aborted_n;
    logic        rd_q, rd_n;
    logic [3:0]  txd_n;
    logic        tx_en_n, tx_er_n, busy_n, done_n, underrun_n;

    assign fifo.o_fifo_rd = rd_q;
    assign dbg_state      = state;

`ifdef ETH_TX_FCS_EN
    logic [31:0] crc_state;
    logic        crc_clear;
    logic        crc_en;

    // The CRC absorbs each payload nibble on the edge that puts it on o_txd,
    // so the state is complete when the last payload nibble is on the wire.
    assign crc_clear = (state == ST_IDLE);
    assign crc_en    = (state_n == ST_DATA);

    eth_crc32_nibble u_crc (
        .clk    (clk),
        .rst    (rst),
        .clear  (crc_clear),
        .enable (crc_en),
        .din    (txd_n),
        .crc    (crc_state)
    );
`endif

    // Next-state and next-output logic for the framing FSM.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        words_n    = words_left;
        shreg_n    = shreg;
        aborted_n  = aborted;
        txd_n      = 4'h0;
        tx_en_n    = 1'b0;
        tx_er_n    = 1'b0;
        rd_n       = 1'b0;
        busy_n     = o_busy;
        done_n     = 1'b0;
        underrun_n = 1'b0;

        case (state)
            ST_IDLE: begin
                if (i_tx_start && (i_word_count != 9'd0)) begin
                    state_n   = ST_PREAMBLE;
                    cnt_n     = 16'd0;
                    words_n   = i_word_count;
                    aborted_n = 1'b0;
                    busy_n    = 1'b1;
                    tx_en_n   = 1'b1;
                    txd_n     = PREAMBLE_NIBBLE;
                end
            end

            ST_PREAMBLE: begin
                tx_en_n = 1'b1;
                if (cnt == PRE_LAST) begin
                    state_n = ST_SFD;
                    cnt_n   = 16'd0;
                    txd_n   = SFD_NIBBLE;
                    rd_n    = ~fifo.i_fifo_empty;
                end else begin
                    cnt_n = cnt + 16'd1;
                    txd_n = PREAMBLE_NIBBLE;
                end
            end

            ST_SFD: begin
                tx_en_n = 1'b1;
                if (rd_q) begin
                    state_n = ST_DATA;
                    cnt_n   = 16'd0;
                    shreg_n = fifo.i_fifo_data;
                    words_n = words_left - 9'd1;
                    txd_n   = fifo.i_fifo_data[3:0];
                end else begin
                    state_n    = ST_ABORT;
                    tx_er_n    = 1'b1;
                    underrun_n = 1'b1;
                    aborted_n  = 1'b1;
                end
            end

            ST_DATA: begin
                tx_en_n = 1'b1;
                if (cnt == WORD_LAST) begin
                    if (words_left == 9'd0) begin
`ifdef ETH_TX_FCS_EN
                        state_n = ST_FCS;
                        cnt_n   = 16'd0;
                        shreg_n = ~crc_state;
                        txd_n   = ~crc_state[3:0];
`else
                        state_n = ST_IFG;
                        cnt_n   = 16'd0;
                        tx_en_n = 1'b0;
`endif
                    end else if (rd_q) begin
                        cnt_n   = 16'd0;
                        shreg_n = fifo.i_fifo_data;
                        words_n = words_left - 9'd1;
                        txd_n   = fifo.i_fifo_data[3:0];
                    end else begin
                        state_n    = ST_ABORT;
                        tx_er_n    = 1'b1;
                        underrun_n = 1'b1;
                        aborted_n  = 1'b1;
                    end
                end else begin
                    cnt_n   = cnt + 16'd1;
                    shreg_n = shreg >> 4;
                    txd_n   = shreg[7:4];
                    // Next cycle carries the 8th nibble: request the next word now.
                    if (cnt == (WORD_LAST - 16'd1)) begin
                        rd_n = (words_left != 9'd0) && !fifo.i_fifo_empty;
                    end
                end
            end

`ifdef ETH_TX_FCS_EN
            ST_FCS: begin
                if (cnt == WORD_LAST) begin
                    state_n = ST_IFG;
                    cnt_n   = 16'd0;
                end else begin
                    tx_en_n = 1'b1;
                    cnt_n   = cnt + 16'd1;
                    shreg_n = shreg >> 4;
                    txd_n   = shreg[7:4];
                end
            end
`endif

            ST_ABORT: begin
                state_n = ST_IFG;
                cnt_n   = 16'd0;
            end

            ST_IFG: begin
                if (cnt == IFG_LAST) begin
                    state_n = ST_IDLE;
                    cnt_n   = 16'd0;
                    busy_n  = 1'b0;
                    done_n  = ~aborted;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end

            default: begin
                state_n = ST_IDLE;
                cnt_n   = 16'd0;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; reset drops the MII pins at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= 16'd0;
            words_left <= 9'd0;
            shreg      <= 32'd0;
            aborted    <= 1'b0;
            rd_q       <= 1'b0;
            o_txd      <= 4'h0;
            o_tx_en    <= 1'b0;
            o_tx_er    <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_underrun <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            words_left <= words_n;
            shreg      <= shreg_n;
            aborted    <= aborted_n;
            rd_q       <= rd_n;
            o_txd      <= txd_n;
            o_tx_en    <= tx_en_n;
            o_tx_er    <= tx_er_n;
            o_busy     <= busy_n;
            o_done     <= done_n;
            o_underrun <= underrun_n;
        end
    end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Self-checking bench for eth_tx_framer: FIFO model, expected-nibble
// scoreboard, per-frame counters and a final summary.
module tb_eth_tx_framer;
    import eth_pkg::*;

    localparam int IFG = 24;
`ifdef ETH_TX_FCS_EN
    localparam int OVERHEAD = 24;
`else
    localparam int OVERHEAD = 16;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_tx_start = 1'b0;
    logic [8:0]  i_word_count = 9'd0;
    logic [3:0]  o_txd;
    logic        o_tx_en, o_tx_er, o_busy, o_done, o_underrun;
    eth_state_e  dbg_state;

    eth_tx_framer_if fifo_if();

    eth_tx_framer #(.IFG_NIBBLES(IFG)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_tx_start   (i_tx_start),
        .i_word_count (i_word_count),
        .fifo         (fifo_if),
        .o_txd        (o_txd),
        .o_tx_en      (o_tx_en),
        .o_tx_er      (o_tx_er),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_underrun   (o_underrun),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [3:0]  exp_q[$];
    logic [31:0] fifo_q[$];
    logic [31:0] frame_words[$];
    bit          mon_en = 1'b0;
    bit          pop_pend = 1'b0;
    int          tx_en_cnt = 0, er_cnt = 0, ur_cnt = 0;
    int          done_cnt = 0, rd_cnt = 0, ifg_cnt = 0;

    logic [3:0]  ref_data [8] = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h3, 4'h0, 4'h4, 4'h0};
    logic [3:0]  ref_fcs  [8] = '{4'hD, 4'hC, 4'hB, 4'hF, 4'hC, 4'h3, 4'h6, 4'hB};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- FIFO model ----------------
    function automatic void fifo_refresh();
        fifo_if.i_fifo_empty = (fifo_q.size() == 0);
        fifo_if.i_fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
    endfunction

    always @(posedge clk) begin
        if (pop_pend) begin
            #1;
            if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            fifo_refresh();
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        pop_pend = fifo_if.o_fifo_rd;
        if (mon_en) begin
            if (o_tx_en) begin
                tx_en_cnt++;
                if (exp_q.size() == 0) check_eq("tx_en_beyond_frame", 32'(o_tx_en), 32'd0);
                else                   check_eq("txd", 32'(o_txd), 32'(exp_q.pop_front()));
            end else begin
                check_eq("txd_idle", 32'(o_txd), 32'd0);
            end
            if (o_tx_er) begin
                er_cnt++;
                check_eq("er_with_underrun", 32'(o_underrun), 32'd1);
            end
            if (o_underrun)        ur_cnt++;
            if (o_done)            done_cnt++;
            if (fifo_if.o_fifo_rd) rd_cnt++;
            if (o_busy && !o_tx_en) ifg_cnt++;
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] crc_bits(input logic [31:0] crc, input logic [3:0] nib);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int b = 0; b < 4; b++) begin
            fb = c[0] ^ nib[b];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    // Load frame_words into the FIFO and queue the nibbles the wire should carry.
    task automatic queue_frame(input int n);
        logic [31:0] crc;
        logic [31:0] fcs;
        logic [3:0]  nib;
        int          avail;
        crc   = 32'hFFFFFFFF;
        avail = frame_words.size();
        foreach (frame_words[i]) fifo_q.push_back(frame_words[i]);
        fifo_refresh();
        repeat (15) exp_q.push_back(4'h5);
        exp_q.push_back(4'hD);
        for (int w = 0; w < n; w++) begin
            if (w >= avail) begin
                exp_q.push_back(4'h0);
                frame_words.delete();
                return;
            end
            for (int k = 0; k < 8; k++) begin
                nib = frame_words[w][4*k +: 4];
                exp_q.push_back(nib);
                crc = crc_bits(crc, nib);
            end
        end
`ifdef ETH_TX_FCS_EN
        fcs = ~crc;
        for (int k = 0; k < 8; k++) exp_q.push_back(fcs[4*k +: 4]);
`else
        fcs = crc;
`endif
        frame_words.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_start(input int n);
        @(posedge clk); #2;
        i_tx_start   = 1'b1;
        i_word_count = 9'(n);
        @(posedge clk); #1;
        i_tx_start   = 1'b0;
    endtask

    task automatic wait_frame_end(input int budget);
        int n;
        n = 0;
        @(posedge clk); #2;
        while (o_busy && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        if (o_busy) check_eq("frame_timeout", 32'(o_busy), 32'd0);
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic clear_counts();
        tx_en_cnt = 0; er_cnt = 0; ur_cnt = 0;
        done_cnt = 0; rd_cnt = 0; ifg_cnt = 0;
    endtask

    task automatic check_frame(input int len, input int rd, input int done, input int ur);
        check_eq("tx_en_cycles", 32'(tx_en_cnt), 32'(len));
        check_eq("fifo_rd_count", 32'(rd_cnt), 32'(rd));
        check_eq("done_count", 32'(done_cnt), 32'(done));
        check_eq("underrun_count", 32'(ur_cnt), 32'(ur));
        check_eq("tx_er_count", 32'(er_cnt), 32'(ur));
        check_eq("ifg_cycles", 32'(ifg_cnt), 32'(IFG));
        check_eq("exp_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        clear_counts();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        fifo_refresh();

        // Reset state.
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_txd", 32'(o_txd), 32'd0);
        check_eq("rst_tx_en", 32'(o_tx_en), 32'd0);
        check_eq("rst_tx_er", 32'(o_tx_er), 32'd0);
        check_eq("rst_fifo_rd", 32'(fifo_if.o_fifo_rd), 32'd0);
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        check_eq("rst_done", 32'(o_done), 32'd0);
        check_eq("rst_underrun", 32'(o_underrun), 32'd0);

        // Single word 0x04030201, start on the first edge after release.
        fifo_q.push_back(32'h04030201);
        fifo_refresh();
        repeat (15) exp_q.push_back(4'h5);
        exp_q.push_back(4'hD);
        for (int i = 0; i < 8; i++) exp_q.push_back(ref_data[i]);
`ifdef ETH_TX_FCS_EN
        for (int i = 0; i < 8; i++) exp_q.push_back(ref_fcs[i]);
`endif
        mon_en = 1'b1;
        @(posedge clk); #2;
        rst          = 1'b1;
        i_tx_start   = 1'b1;
        i_word_count = 9'd1;
        @(posedge clk); #1;
        i_tx_start   = 1'b0;
        check_eq("first_start_tx_en", 32'(o_tx_en), 32'd1);
        check_eq("first_start_txd", 32'(o_txd), 32'h5);
        check_eq("first_start_busy", 32'(o_busy), 32'd1);
        wait_frame_end(400);
        check_frame(OVERHEAD + 8, 1, 1, 0);

        // Underrun at the second load: count 3, one word in the FIFO.
        frame_words.push_back(32'hA5C31E7F);
        queue_frame(3);
        send_start(3);
        wait_frame_end(400);
        check_frame(16 + 8 + 1, 1, 0, 1);

        // Underrun at the SFD load: FIFO empty from the start.
        queue_frame(1);
        send_start(1);
        wait_frame_end(400);
        check_frame(17, 0, 0, 1);

        // Count 0 start is ignored.
        send_start(0);
        check_eq("zero_count_busy", 32'(o_busy), 32'd0);
        repeat (5) @(posedge clk);
        #2;
        check_eq("zero_count_tx_en", 32'(o_tx_en), 32'd0);

        // Two-word frame with a start pulse during DATA that must be ignored.
        frame_words.push_back($urandom);
        frame_words.push_back($urandom);
        queue_frame(2);
        send_start(2);
        repeat (20) @(posedge clk);
        check_eq("mid_frame_state", 32'(dbg_state), 32'(ST_DATA));
        send_start(5);
        wait_frame_end(400);
        check_frame(OVERHEAD + 16, 2, 1, 0);

        // Random-length frames with random payload.
        for (int t = 0; t < 4; t++) begin
            n = $urandom_range(1, 6);
            for (int w = 0; w < n; w++) frame_words.push_back($urandom);
            queue_frame(n);
            send_start(n);
            wait_frame_end(600);
            check_frame(OVERHEAD + 8 * n, n, 1, 0);
        end

        // Reset asserted at the 10th payload nibble.
        mon_en = 1'b0;
        for (int w = 0; w < 3; w++) fifo_q.push_back($urandom);
        fifo_refresh();
        send_start(3);
        repeat (25) @(posedge clk);
        #2;
        check_eq("pre_rst_state", 32'(dbg_state), 32'(ST_DATA));
        check_eq("pre_rst_tx_en", 32'(o_tx_en), 32'd1);
        rst = 1'b0;
        #1;
        check_eq("async_rst_tx_en", 32'(o_tx_en), 32'd0);
        check_eq("async_rst_txd", 32'(o_txd), 32'd0);
        check_eq("async_rst_tx_er", 32'(o_tx_er), 32'd0);
        check_eq("async_rst_fifo_rd", 32'(fifo_if.o_fifo_rd), 32'd0);
        check_eq("async_rst_busy", 32'(o_busy), 32'd0);
        check_eq("async_rst_underrun", 32'(o_underrun), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        check_eq("async_rst_done", 32'(o_done), 32'd0);
        fifo_q.delete();
        fifo_refresh();
        exp_q.delete();
        clear_counts();
        rst = 1'b1;
        mon_en = 1'b1;

        // Full frame after the mid-frame reset.
        frame_words.push_back($urandom);
        frame_words.push_back($urandom);
        queue_frame(2);
        send_start(2);
        wait_frame_end(400);
        check_frame(OVERHEAD + 16, 2, 1, 0);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
